// File: rtl/servo_pkg.sv
// Shared types and default timing for the servo PWM path (25 MHz clock).
package servo_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_RISE,
    HIGH,
    QUANT
  } cap_state_t;

  typedef logic [19:0] width_t;
  typedef logic [3:0]  angle_t;

  localparam int unsigned DEF_MIN_W    = 25000;
  localparam int unsigned DEF_STEP     = 1666;
  localparam int unsigned DEF_RUNT_W   = 12500;
  localparam int unsigned DEF_HIGH_MAX = 62500;
  localparam int unsigned DEF_LOST_MAX = 750000;
  localparam int unsigned DEF_FILT_LEN = 8;

endpackage

// File: rtl/pwm_in_cond.sv
// PWM input conditioning: 2-flop synchronizer, optional deglitch, edge detect.
// Deglitch stage is present only when PWM_CAPTURE_FILTER_EN is defined.
module pwm_in_cond #(
  parameter int unsigned FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm,
  output logic level,
  output logic rise,
  output logic fall,
  output logic ready
);

  logic       sync_q1;
  logic       sync_q2;
  logic [1:0] prime_q;
  logic       level_d;

  // prime_q[1] marks that sync_q2 holds a real sample rather than its reset value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      prime_q <= 2'b00;
    end else begin
      sync_q1 <= pwm;
      sync_q2 <= sync_q1;
      prime_q <= {prime_q[0], 1'b1};
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(FILT_LEN - 1);

  logic [CW-1:0] stab_cnt;
  logic          filt_q;
  logic          filt_primed;

  // Filter output is seeded from the first real sample, then only follows
  // a new level that has held for FILT_LEN consecutive clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q      <= 1'b0;
      filt_primed <= 1'b0;
      stab_cnt    <= RELOAD;
    end else if (!filt_primed) begin
      filt_q      <= sync_q2;
      filt_primed <= prime_q[1];
    end else if (sync_q2 == filt_q) begin
      stab_cnt <= RELOAD;
    end else if (stab_cnt == '0) begin
      filt_q   <= sync_q2;
      stab_cnt <= RELOAD;
    end else begin
      stab_cnt <= stab_cnt - CW'(1);
    end
  end

  assign level = filt_q;
  assign ready = filt_primed;
`else
  assign level = sync_q2;
  assign ready = prime_q[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_d <= 1'b0;
    else        level_d <= level;
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

endmodule

// File: rtl/pwm_capture.sv
// Servo PWM receiver: measures pulse high time and quantizes it to a 4-bit angle code.
// Define PWM_CAPTURE_FILTER_EN to insert the FILT_LEN-clock input deglitch stage.
//
// state     | meaning
// WAIT_LOW  | wait for a settled low input so a pulse already in progress is skipped
// WAIT_RISE | idle low, waiting for the next rising edge
// HIGH      | counting high time, checking runt / over-long limits
// QUANT     | repeated subtraction of STEP from (width - MIN_W) to form the angle code
module pwm_capture
  import servo_pkg::*;
#(
  parameter int unsigned MIN_W    = DEF_MIN_W,
  parameter int unsigned STEP     = DEF_STEP,
  parameter int unsigned RUNT_W   = DEF_RUNT_W,
  parameter int unsigned HIGH_MAX = DEF_HIGH_MAX,
  parameter int unsigned LOST_MAX = DEF_LOST_MAX,
  parameter int unsigned FILT_LEN = DEF_FILT_LEN
) (
  input  logic   i_Clk,
  input  logic   clr_n,
  input  logic   i_Pwm,
  output angle_t o_angle,
  output width_t o_width,
  output logic   o_valid,
  output logic   o_err,
  output logic   o_lost
);

  localparam width_t MIN_V  = width_t'(MIN_W);
  localparam width_t STEP_V = width_t'(STEP);
  localparam width_t RUNT_V = width_t'(RUNT_W);
  localparam width_t HMAX_V = width_t'(HIGH_MAX);
  localparam int     LW     = $clog2(LOST_MAX + 1);
  localparam logic [LW-1:0] LOST_V   = LW'(LOST_MAX);
  localparam logic [LW-1:0] LOST_PRE = LW'(LOST_MAX - 1);

  logic s, rise, fall, ready;

  pwm_in_cond #(
    .FILT_LEN(FILT_LEN)
  ) u_in_cond (
    .clk  (i_Clk),
    .rst_n(clr_n),
    .pwm  (i_Pwm),
    .level(s),
    .rise (rise),
    .fall (fall),
    .ready(ready)
  );

  cap_state_t    state, state_nxt;
  width_t        width, rem;
  angle_t        q;
  logic [LW-1:0] lost_cnt;
  logic          width_ld, width_inc, quant_ld, quant_step, cap_done, err_set;
  logic          lost_win;

  always_ff @(posedge i_Clk or negedge clr_n) begin
    if (!clr_n) state <= WAIT_LOW;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    width_ld   = 1'b0;
    width_inc  = 1'b0;
    quant_ld   = 1'b0;
    quant_step = 1'b0;
    cap_done   = 1'b0;
    err_set    = 1'b0;
    case (state)
      WAIT_LOW: begin
        if (ready && !s) state_nxt = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) begin
          width_ld  = 1'b1;
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        // Over-long wins over a coincident fall so no width above HIGH_MAX is reported.
        if (width > HMAX_V) begin
          err_set   = 1'b1;
          state_nxt = WAIT_LOW;
        end else if (fall) begin
          if (width < RUNT_V) begin
            err_set   = 1'b1;
            state_nxt = WAIT_RISE;
          end else begin
            quant_ld  = 1'b1;
            state_nxt = QUANT;
          end
        end else begin
          width_inc = 1'b1;
        end
      end
      QUANT: begin
        if (rem >= STEP_V && q != 4'd15) begin
          quant_step = 1'b1;
        end else begin
          cap_done  = 1'b1;
          state_nxt = WAIT_RISE;
        end
      end
      default: state_nxt = WAIT_LOW;
    endcase
  end

  always_ff @(posedge i_Clk or negedge clr_n) begin
    if (!clr_n) begin
      width <= '0;
      rem   <= '0;
      q     <= '0;
    end else begin
      if (width_ld)                       width <= 20'd1;
      else if (width_inc && width != '1)  width <= width + 20'd1;
      if (quant_ld) begin
        rem <= (width > MIN_V) ? (width - MIN_V) : '0;
        q   <= '0;
      end else if (quant_step) begin
        rem <= rem - STEP_V;
        q   <= q + 4'd1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge clr_n) begin
    if (!clr_n) begin
      o_angle <= '0;
      o_width <= '0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_valid <= cap_done;
      if (cap_done) begin
        o_angle <= q;
        o_width <= width;
        o_err   <= 1'b0;
      end else if (err_set) begin
        o_err <= 1'b1;
      end
    end
  end

  assign lost_win = (state == WAIT_LOW) || (state == WAIT_RISE);

  // Loss timer holds at LOST_MAX; o_lost rises on the same edge the count lands there.
  always_ff @(posedge i_Clk or negedge clr_n) begin
    if (!clr_n) begin
      lost_cnt <= '0;
      o_lost   <= 1'b0;
    end else begin
      if (rise)                                 lost_cnt <= '0;
      else if (lost_win && lost_cnt != LOST_V)  lost_cnt <= lost_cnt + LW'(1);
      if (cap_done)                                        o_lost <= 1'b0;
      else if (!rise && lost_win && lost_cnt == LOST_PRE)  o_lost <= 1'b1;
    end
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Servo-PWM receiver: measures the high time of an incoming 50 Hz servo-style pulse train, such as an RC receiver channel or a loop-back from a PMOD servo pin. It quantizes that high time into the same 4-bit angle code the servo drive path consumes. It sits beside the servo interface and feeds manual/automatic angle selection with a decoded angle, a one-cycle valid strobe and error/loss status.

## Interface
Parameters:
- MIN_W, 25000: pulse width in clocks mapped to angle 0 (1 ms at 25 MHz).
- STEP, 1666: clocks per angle code step.
- RUNT_W, 12500: widths below this are errors (0.5 ms).
- HIGH_MAX, 62500: widths above this are errors (2.5 ms).
- LOST_MAX, 750000: clocks with no rising edge before loss is declared (30 ms).
- FILT_LEN, 8: deglitch stability length in clocks; used only with filter enabled.

Ports:
- i_Clk, in, 1: single clock.
- clr_n, in, 1: asynchronous active-low reset.
- i_Pwm, in, 1: asynchronous PWM input.
- o_angle, out, 4: last decoded angle code.
- o_width, out, 20: last measured high width in clocks.
- o_valid, out, 1: one-cycle strobe when o_angle/o_width update.
- o_err, out, 1: last pulse rejected (runt or over-long); sticky until next o_valid.
- o_lost, out, 1: no rising edge for LOST_MAX clocks; cleared by next o_valid.

## Operation
- i_Pwm passes through a 2-flop synchronizer, then an edge detector; all logic uses the synchronized level `s`.
- FSM states:
  - WAIT_LOW (reset state): wait until s==0, then go to WAIT_RISE. This prevents capturing a pulse already in progress.
  - WAIT_RISE: on rising edge, clear width counter to 1 and go to HIGH.
  - HIGH: width counter increments each cycle.
    - On falling edge: width < RUNT_W sets o_err and goes to WAIT_RISE; otherwise go to QUANT.
    - If counter exceeds HIGH_MAX while still high: set o_err and go to WAIT_LOW.
  - QUANT: sequential subtract, one step per cycle.
    - r = width − MIN_W (clamped at 0 if width < MIN_W), q = 0.
    - While r ≥ STEP and q < 15: r −= STEP, q++.
    - On exit: o_angle=q, o_width=width, o_valid=1 for one cycle, o_err=0, o_lost=0; go to WAIT_RISE.
- Width arithmetic is 20-bit unsigned; counter saturates at 2^20−1.
- Loss timer:
  - Counts in WAIT_LOW and WAIT_RISE; cleared on every rising edge.
  - Reaching LOST_MAX sets o_lost and holds the timer; o_angle/o_width keep their last values.
- A rising edge during QUANT is ignored; that pulse is dropped and the FSM resumes in WAIT_RISE.
- Reset mid-pulse: all outputs return to 0 and the FSM goes to WAIT_LOW; the interrupted pulse is never reported.

## Timing
- Reset values: o_angle=0, o_width=0, o_valid=0, o_err=0, o_lost=0; FSM in WAIT_LOW; counters 0.
- Input latency is 2 clocks from i_Pwm to `s`, or 2+FILT_LEN clocks with the filter enabled.
- The measured width equals the true high time in clocks, within ±1 clock.
- o_valid asserts q+2 clocks after the cycle the falling edge is detected. The maximum is 17 clocks.
- o_valid is never asserted in two consecutive cycles.
- o_err sets in the cycle after detection; o_lost sets on the clock the timer reaches LOST_MAX.

## Configuration
- PWM_CAPTURE_FILTER_EN defined: a deglitch stage sits between synchronizer and edge detector. `s` changes only after the synchronized input holds a new level for FILT_LEN consecutive clocks, so glitches shorter than FILT_LEN are ignored.
- Undefined: `s` is the raw synchronizer output; FILT_LEN is unused.

## Structure
- Shared package servo_pkg holds:
  - the FSM state enum (WAIT_LOW, WAIT_RISE, HIGH, QUANT);
  - the 20-bit width typedef;
  - the 4-bit angle typedef;
  - default timing constants MIN_W, STEP, RUNT_W, HIGH_MAX, LOST_MAX.
- One sub-module, pwm_in_cond: synchronizer, optional deglitch, and rise/fall edge outputs.

## Test plan
- 1.0 ms pulse (25000 clocks) every 20 ms → o_valid with o_angle=0, o_width=25000±1, o_err=0.
- 2.0 ms pulse (50000 clocks) → o_angle=15. 1.5 ms pulse (37500 clocks) → o_angle=7. 2.2 ms pulse (55000 clocks) → o_angle=15 (clamped).
- 0.3 ms runt (7500 clocks) → no o_valid, o_err=1. Next good 1.5 ms pulse → o_angle=7, o_err=0.
- Input held high 3 ms → o_err=1, no o_valid. No capture occurs until the input goes low and a fresh rising edge arrives.
- Input stuck low 31 ms after a good pulse → o_lost=1 at 30 ms, o_angle holds last value. Next pulse → o_lost=0.
- Input already high at reset release → no o_valid for that pulse; the first valid comes from the next pulse. With PWM_CAPTURE_FILTER_EN, a 4-clock glitch during the low phase → no edge, no change to any output.
